// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings and the
// default address/instruction width.
package ifetch_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_if.sv
// Fetch unit bus: PC block control, instruction memory read port and the
// decode-facing instruction queue head.
interface ifetch_if
  import ifetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
);

  logic            i_pc_dummy_unused_guard;
  logic [XLEN-1:0] i_pc;
  logic            o_pc_en;
  logic            i_redirect;
  logic            o_mem_req;
  logic [XLEN-1:0] o_mem_addr;
  logic            i_mem_ack;
  logic [XLEN-1:0] i_mem_rdata;
  logic            o_inst_valid;
  logic [XLEN-1:0] o_inst;
  logic [XLEN-1:0] o_inst_pc;
  logic            i_inst_ready;

  assign i_pc_dummy_unused_guard = 1'b0;

  // The fetch unit is the bus master toward memory and the PC block.
  modport master (
    input  i_pc, i_redirect, i_mem_ack, i_mem_rdata, i_inst_ready,
    output o_pc_en, o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc
  );

  modport slave (
    output i_pc, i_redirect, i_mem_ack, i_mem_rdata, i_inst_ready,
    input  o_pc_en, o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc
  );

endinterface

// File: rtl/ifetch_fifo.sv
// Instruction queue: DEPTH-entry FIFO of {pc, instruction} pairs with a
// synchronous flush that overrides any push or pop in the same cycle.
module ifetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero while held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: keeps one memory read in flight, queues returned
// instructions for decode and discards fetches overtaken by a redirect.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input logic      i_CLK,
  input logic      i_RST_N,
  ifetch_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [XLEN-1:0]   addr_q;
  logic              issue;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              room;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] head;

  assign pop  = !empty && bus.i_inst_ready;
  // Equivalent to (count + pop) < DEPTH without widening the counter.
  assign room = !full && !(pop && (count == CW'(DEPTH - 1)));

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (i_RST_N && !bus.i_redirect && room) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.i_redirect) begin
          state_nxt = bus.i_mem_ack ? IDLE : DROP;
        end else if (bus.i_mem_ack) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      // A redirect here only keeps us waiting; the stale ack still retires it.
      DROP: begin
        if (bus.i_mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state  <= IDLE;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (issue) addr_q <= bus.i_pc;
    end
  end

  assign bus.o_mem_req    = issue;
  assign bus.o_pc_en      = issue;
  assign bus.o_mem_addr   = issue ? bus.i_pc : addr_q;
  assign bus.o_inst_valid = !empty;
  assign bus.o_inst_pc    = head[2*XLEN-1:XLEN];
  assign bus.o_inst       = head[XLEN-1:0];

  ifetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(2 * XLEN)
  ) u_fifo (
    .clk  (i_CLK),
    .rst_n(i_RST_N),
    .push (push),
    .pop  (pop),
    .flush(bus.i_redirect),
    .din  ({addr_q, bus.i_mem_rdata}),
    .full (full),
    .empty(empty),
    .dout (head),
    .count(count)
  );

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: acts as PC block, instruction memory and decode,
// comparing outputs against hand-derived values.
module tb_ifetch;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  ifetch_if #(.XLEN(XLEN)) bus ();

  ifetch #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .i_CLK  (clk),
    .i_RST_N(rst_n),
    .bus    (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          cd          = 0;
  logic        outstanding = 1'b0;
  logic [31:0] pc          = 32'h0;
  logic [31:0] pend_addr   = 32'h0;

  logic        s_req, s_pc_en, s_valid, s_pop;
  logic [31:0] s_addr, s_inst, s_inst_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: memory responds after 'lat' cycles, PC advances on pc_en.
  task automatic applyStimulus(input logic ready, input logic redirect, input logic [31:0] new_pc, input int lat);
    bus.i_pc         = pc;
    bus.i_inst_ready = ready;
    bus.i_redirect   = redirect;
    bus.i_mem_ack    = 1'b0;
    bus.i_mem_rdata  = 32'h0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = mem_word(pend_addr);
        outstanding     = 1'b0;
      end
    end
    #2;
    s_req     = bus.o_mem_req;
    s_pc_en   = bus.o_pc_en;
    s_valid   = bus.o_inst_valid;
    s_addr    = bus.o_mem_addr;
    s_inst    = bus.o_inst;
    s_inst_pc = bus.o_inst_pc;
    s_pop     = s_valid && ready;
    checkOutput("pc_en_without_req", {31'b0, s_pc_en && !s_req}, 32'h0);
    checkOutput("second_outstanding", {31'b0, s_req && outstanding}, 32'h0);
    if (s_req) begin
      outstanding = 1'b1;
      pend_addr   = s_addr;
      cd          = lat;
    end
    if (redirect) pc = new_pc;
    else if (s_pc_en) pc = pc + 32'd4;
    step();
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    rst_n            = 1'b0;
    bus.i_mem_ack    = 1'b0;
    bus.i_redirect   = 1'b0;
    bus.i_inst_ready = 1'b0;
    cd               = 0;
    outstanding      = 1'b0;
    pc               = start_pc;
    bus.i_pc         = start_pc;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int reqs;
    int popped;
    int cycles;
    logic [31:0] exp_pc;

    bus.i_pc         = 32'h56;
    bus.i_redirect   = 1'b0;
    bus.i_mem_ack    = 1'b0;
    bus.i_mem_rdata  = 32'h0;
    bus.i_inst_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_mem_req", {31'b0, bus.o_mem_req}, 32'h0);
    checkOutput("rst_pc_en", {31'b0, bus.o_pc_en}, 32'h0);
    checkOutput("rst_valid", {31'b0, bus.o_inst_valid}, 32'h0);
    checkOutput("rst_mem_addr", bus.o_mem_addr, 32'h0);
    checkOutput("rst_inst", bus.o_inst, 32'h0);
    checkOutput("rst_inst_pc", bus.o_inst_pc, 32'h0);

    // Basic fetch with one-cycle ack
    do_reset(32'h56);
    applyStimulus(1'b1, 1'b0, 32'h0, 1);
    checkOutput("a_req", {31'b0, s_req}, 32'h1);
    checkOutput("a_pc_en", {31'b0, s_pc_en}, 32'h1);
    checkOutput("a_addr", s_addr, 32'h56);
    checkOutput("a_valid_c1", {31'b0, s_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1);
    checkOutput("a_req_c2", {31'b0, s_req}, 32'h0);
    checkOutput("a_pc_en_c2", {31'b0, s_pc_en}, 32'h0);
    checkOutput("a_addr_hold", s_addr, 32'h56);
    checkOutput("a_valid_c2", {31'b0, s_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1);
    checkOutput("a_valid_c3", {31'b0, s_valid}, 32'h1);
    checkOutput("a_inst_pc", s_inst_pc, 32'h56);
    checkOutput("a_inst", s_inst, 32'hA5A5_0056);

    // Backpressure: queue fills to DEPTH, then one pop lets one more fetch in
    do_reset(32'h200);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1);
      if (s_req) reqs++;
      if (i == 4) checkOutput("b_head_stall_c5", s_inst_pc, 32'h200);
    end
    checkOutput("b_req_count", reqs, DEPTH);
    checkOutput("b_valid", {31'b0, s_valid}, 32'h1);
    checkOutput("b_head_stall", s_inst_pc, 32'h200);
    checkOutput("b_inst_stall", s_inst, 32'hA5A5_0200);
    reqs = 0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1);
    if (s_req) reqs++;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1);
      if (s_req) reqs++;
    end
    checkOutput("b_extra_reqs", reqs, 1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1);
    checkOutput("b_head_2", s_inst_pc, 32'h204);
    applyStimulus(1'b1, 1'b0, 32'h0, 1);
    checkOutput("b_head_3", s_inst_pc, 32'h208);

    // Redirect during the second WAIT cycle with three-cycle ack latency
    do_reset(32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0, 3);
    checkOutput("c_req", {31'b0, s_req}, 32'h1);
    checkOutput("c_addr", s_addr, 32'h40);
    applyStimulus(1'b1, 1'b0, 32'h0, 3);
    checkOutput("c_wait1_req", {31'b0, s_req}, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h100, 3);
    checkOutput("c_redirect_req", {31'b0, s_req}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 3);
    checkOutput("c_drop_req", {31'b0, s_req}, 32'h0);
    checkOutput("c_drop_valid", {31'b0, s_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 3);
    checkOutput("c_new_req", {31'b0, s_req}, 32'h1);
    checkOutput("c_new_addr", s_addr, 32'h100);
    checkOutput("c_new_valid", {31'b0, s_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 3);
    applyStimulus(1'b1, 1'b0, 32'h0, 3);
    applyStimulus(1'b1, 1'b0, 32'h0, 3);
    checkOutput("c_ack_valid", {31'b0, s_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 3);
    checkOutput("c_head_valid", {31'b0, s_valid}, 32'h1);
    checkOutput("c_head_pc", s_inst_pc, 32'h100);
    checkOutput("c_head_inst", s_inst, 32'hA5A5_0100);

    // Redirect coincident with ack and pop, then with pop on a full queue
    do_reset(32'h300);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    applyStimulus(1'b1, 1'b1, 32'h400, 1);
    checkOutput("d_pre_valid", {31'b0, s_valid}, 32'h1);
    checkOutput("d_pre_pc", s_inst_pc, 32'h300);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    checkOutput("d_flush_valid", {31'b0, s_valid}, 32'h0);
    checkOutput("d_idle_req", {31'b0, s_req}, 32'h1);
    checkOutput("d_idle_addr", s_addr, 32'h400);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    checkOutput("d_full_req", {31'b0, s_req}, 32'h0);
    checkOutput("d_full_valid", {31'b0, s_valid}, 32'h1);
    checkOutput("d_full_pc", s_inst_pc, 32'h400);
    applyStimulus(1'b1, 1'b1, 32'h500, 1);
    checkOutput("d_redir_req", {31'b0, s_req}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1);
    checkOutput("d_full_flush_valid", {31'b0, s_valid}, 32'h0);
    checkOutput("d_after_req", {31'b0, s_req}, 32'h1);
    checkOutput("d_after_addr", s_addr, 32'h500);

    // Asynchronous reset in the middle of a WAIT with a queued instruction
    do_reset(32'h600);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'h0, 3);
    checkOutput("e_pre_valid", {31'b0, bus.o_inst_valid}, 32'h1);
    checkOutput("e_pre_addr", bus.o_mem_addr, 32'h604);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("e_mid_req", {31'b0, bus.o_mem_req}, 32'h0);
    checkOutput("e_mid_pc_en", {31'b0, bus.o_pc_en}, 32'h0);
    checkOutput("e_mid_valid", {31'b0, bus.o_inst_valid}, 32'h0);
    checkOutput("e_mid_addr", bus.o_mem_addr, 32'h0);
    checkOutput("e_mid_inst", bus.o_inst, 32'h0);
    checkOutput("e_mid_inst_pc", bus.o_inst_pc, 32'h0);
    step();
    rst_n       = 1'b1;
    pc          = 32'h700;
    cd          = 1;
    outstanding = 1'b0;
    pend_addr   = 32'h604;
    applyStimulus(1'b0, 1'b0, 32'h0, 3);
    checkOutput("e_stray_req", {31'b0, s_req}, 32'h1);
    checkOutput("e_stray_addr", s_addr, 32'h700);
    applyStimulus(1'b0, 1'b0, 32'h0, 3);
    checkOutput("e_no_push_1", {31'b0, s_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 3);
    checkOutput("e_no_push_2", {31'b0, s_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 3);
    applyStimulus(1'b0, 1'b0, 32'h0, 3);
    checkOutput("e_head_pc", s_inst_pc, 32'h700);
    checkOutput("e_head_inst", s_inst, 32'hA5A5_0700);

    // Random ready and ack stalls: popped stream must follow the PC sequence
    do_reset(32'h1000);
    exp_pc = 32'h1000;
    popped = 0;
    cycles = 0;
    while (popped < 1000 && cycles < 20000) begin
      applyStimulus(($urandom_range(0, 3) != 0), 1'b0, 32'h0, int'($urandom_range(1, 4)));
      if (s_pop) begin
        checkOutput("seq_pc", s_inst_pc, exp_pc);
        checkOutput("seq_inst", s_inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        popped++;
      end
      cycles++;
    end
    checkOutput("seq_complete", popped, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
